// File: rtl/mod_timer_if.sv
// -----------------------------------------------------------------------------
// mod_timer_if
// Purpose : Groups the signals between the controller register block, the
//           modulation sample-index timer and the modulation reader.
// Signals :
//   SYNC_SET    controller -> timer  phase re-alignment request (rising edge)
//   CYCLE_M     controller -> timer  last valid sample index (IDX_WIDTH)
//   FREQ_DIV_M  controller -> timer  CLK cycles per sample (DIV_WIDTH)
//   IDX         timer -> reader      current sample index (IDX_WIDTH)
//   IDX_UPDATE  timer -> reader      one-cycle strobe when IDX takes a new value
//   RUNNING     timer -> reader      high once the first sync has occurred
//   LOOP_CNT    timer -> reader      completed-period counter, present only when
//                                    MOD_TIMER_LOOP_CNT_EN is defined
// Modports:
//   master : controller/bench side (drives configuration, observes outputs)
//   slave  : timer side
// Optional macro: MOD_TIMER_LOOP_CNT_EN
// -----------------------------------------------------------------------------
interface mod_timer_if #(
  parameter int IDX_WIDTH = 16,
  parameter int DIV_WIDTH = 32
);

  logic                 SYNC_SET;
  logic [IDX_WIDTH-1:0] CYCLE_M;
  logic [DIV_WIDTH-1:0] FREQ_DIV_M;
  logic [IDX_WIDTH-1:0] IDX;
  logic                 IDX_UPDATE;
  logic                 RUNNING;
`ifdef MOD_TIMER_LOOP_CNT_EN
  logic [15:0]          LOOP_CNT;
`endif

`ifdef MOD_TIMER_LOOP_CNT_EN
  modport master (
    output SYNC_SET,
    output CYCLE_M,
    output FREQ_DIV_M,
    input  IDX,
    input  IDX_UPDATE,
    input  RUNNING,
    input  LOOP_CNT
  );

  modport slave (
    input  SYNC_SET,
    input  CYCLE_M,
    input  FREQ_DIV_M,
    output IDX,
    output IDX_UPDATE,
    output RUNNING,
    output LOOP_CNT
  );
`else
  modport master (
    output SYNC_SET,
    output CYCLE_M,
    output FREQ_DIV_M,
    input  IDX,
    input  IDX_UPDATE,
    input  RUNNING
  );

  modport slave (
    input  SYNC_SET,
    input  CYCLE_M,
    input  FREQ_DIV_M,
    output IDX,
    output IDX_UPDATE,
    output RUNNING
  );
`endif

endinterface

// File: rtl/mod_timer.sv
// -----------------------------------------------------------------------------
// mod_timer
// Purpose : Modulation sample-index generator. Divides CLK by a shadowed
//           frequency divider and steps IDX modulo (CYCLE_M+1). Phase is
//           re-aligned (IDX=0, prescaler=0) on every rising edge of SYNC_SET.
//           CYCLE_M / FREQ_DIV_M are only sampled at a period boundary or at a
//           sync, so a period is never cut short by a configuration write.
// Ports   :
//   CLK    input   system clock, all state updates on the rising edge
//   RST_N  input   synchronous active-low reset
//   tmr    mod_timer_if.slave
//            SYNC_SET, CYCLE_M, FREQ_DIV_M in; IDX, IDX_UPDATE, RUNNING out
//            (LOOP_CNT out when MOD_TIMER_LOOP_CNT_EN is defined)
// Optional macro: MOD_TIMER_LOOP_CNT_EN
//   Adds a 16-bit saturating count of period boundaries, cleared on sync.
// -----------------------------------------------------------------------------
module mod_timer #(
  parameter int IDX_WIDTH = 16,
  parameter int DIV_WIDTH = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  mod_timer_if.slave  tmr
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_q,        state_d;
  logic                 sync_dly_q,     sync_dly_d;
  logic [DIV_WIDTH-1:0] prescaler_q,    prescaler_d;
  logic [DIV_WIDTH-1:0] shadow_div_q,   shadow_div_d;
  logic [IDX_WIDTH-1:0] shadow_cycle_q, shadow_cycle_d;
  logic [IDX_WIDTH-1:0] idx_q,          idx_d;
  logic                 idx_update_q,   idx_update_d;
  logic                 running_q,      running_d;
`ifdef MOD_TIMER_LOOP_CNT_EN
  logic [15:0]          loop_cnt_q,     loop_cnt_d;
`endif

  logic                 sync_rise;
  logic [DIV_WIDTH-1:0] div_eff;
  logic                 div_terminal;
  logic                 period_end;

  assign sync_rise = tmr.SYNC_SET & ~sync_dly_q;

  // A divider of 0 would never terminate; treat it as divide-by-1.
  assign div_eff = (tmr.FREQ_DIV_M == '0) ? DIV_WIDTH'(1) : tmr.FREQ_DIV_M;

  // shadow_div_q is never 0, so the subtraction cannot underflow.
  assign div_terminal = (prescaler_q == (shadow_div_q - 1'b1));

  // ">=" rather than "==" so a corrupted IDX above the cycle length still
  // wraps instead of running through the whole index space.
  assign period_end = (idx_q >= shadow_cycle_q);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q        <= IDLE;
      sync_dly_q     <= 1'b0;
      prescaler_q    <= '0;
      shadow_div_q   <= DIV_WIDTH'(1);
      shadow_cycle_q <= '0;
      idx_q          <= '0;
      idx_update_q   <= 1'b0;
      running_q      <= 1'b0;
`ifdef MOD_TIMER_LOOP_CNT_EN
      loop_cnt_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      sync_dly_q     <= sync_dly_d;
      prescaler_q    <= prescaler_d;
      shadow_div_q   <= shadow_div_d;
      shadow_cycle_q <= shadow_cycle_d;
      idx_q          <= idx_d;
      idx_update_q   <= idx_update_d;
      running_q      <= running_d;
`ifdef MOD_TIMER_LOOP_CNT_EN
      loop_cnt_q     <= loop_cnt_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    sync_dly_d     = tmr.SYNC_SET;
    prescaler_d    = prescaler_q;
    shadow_div_d   = shadow_div_q;
    shadow_cycle_d = shadow_cycle_q;
    idx_d          = idx_q;
    idx_update_d   = 1'b0;
    running_d      = running_q;
`ifdef MOD_TIMER_LOOP_CNT_EN
    loop_cnt_d     = loop_cnt_q;
`endif

    if (sync_rise) begin
      // Sync load takes priority over any divider terminal or boundary
      // happening in the same cycle.
      state_d        = RUN;
      shadow_cycle_d = tmr.CYCLE_M;
      shadow_div_d   = div_eff;
      prescaler_d    = '0;
      idx_d          = '0;
      idx_update_d   = 1'b1;
      running_d      = 1'b1;
`ifdef MOD_TIMER_LOOP_CNT_EN
      loop_cnt_d     = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          idx_d        = '0;
          idx_update_d = 1'b0;
        end

        RUN: begin
          if (div_terminal) begin
            prescaler_d  = '0;
            idx_update_d = 1'b1;
            if (period_end) begin
              // Period boundary: the only point (besides sync) where new
              // configuration is picked up.
              idx_d          = '0;
              shadow_cycle_d = tmr.CYCLE_M;
              shadow_div_d   = div_eff;
`ifdef MOD_TIMER_LOOP_CNT_EN
              if (loop_cnt_q != 16'hFFFF) begin
                loop_cnt_d = loop_cnt_q + 16'd1;
              end
`endif
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            prescaler_d = prescaler_q + 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tmr.IDX        = idx_q;
  assign tmr.IDX_UPDATE = idx_update_q;
  assign tmr.RUNNING    = running_q;
`ifdef MOD_TIMER_LOOP_CNT_EN
  assign tmr.LOOP_CNT   = loop_cnt_q;
`endif

endmodule

// File: tb/tb_mod_timer.sv
// -----------------------------------------------------------------------------
// tb_mod_timer
// Directed bench for mod_timer: reset state, divide/wrap sequence, divider 0,
// deferred configuration change, sync on a divider terminal with SYNC_SET held,
// mid-run reset, and (with MOD_TIMER_LOOP_CNT_EN) the loop counter.
// -----------------------------------------------------------------------------
module tb_mod_timer;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;

  mod_timer_if #(.IDX_WIDTH(16), .DIV_WIDTH(32)) bus ();

  mod_timer #(.IDX_WIDTH(16), .DIV_WIDTH(32)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .tmr   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    nvec++;
    assert (observed === expected)
      else begin
        nerr++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;

    // Reset
    rst_n          = 1'b0;
    bus.SYNC_SET   = 1'b0;
    bus.CYCLE_M    = 16'd3;
    bus.FREQ_DIV_M = 32'd4;
    tick();
    tick();
    check("rst_idx", bus.IDX, 0);
    check("rst_upd", bus.IDX_UPDATE, 0);
    check("rst_run", bus.RUNNING, 0);

    // Idle without sync
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_idx", bus.IDX, 0);
    check("idle_upd", bus.IDX_UPDATE, 0);
    check("idle_run", bus.RUNNING, 0);

    // Cycle 3, div 4: each index held 4 cycles, strobe every 4th cycle
    bus.SYNC_SET = 1'b1;
    tick();
    bus.SYNC_SET = 1'b0;
    check("t1_idx0", bus.IDX, 0);
    check("t1_upd0", bus.IDX_UPDATE, 1);
    check("t1_run", bus.RUNNING, 1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("t1_idx_k%0d", k), bus.IDX, (k / 4) % 4);
      check($sformatf("t1_upd_k%0d", k), bus.IDX_UPDATE, (k % 4) == 0);
    end

    // At IDX=1, write cycle 1 / div 2: old config runs to the boundary
    bus.CYCLE_M    = 16'd1;
    bus.FREQ_DIV_M = 32'd2;
    for (int k = 21; k <= 31; k++) begin
      tick();
      check($sformatf("t3_idx_k%0d", k), bus.IDX, (k / 4) - 4);
      check($sformatf("t3_upd_k%0d", k), bus.IDX_UPDATE, (k % 4) == 0);
    end
    for (int k = 32; k <= 38; k++) begin
      tick();
      check($sformatf("t3n_idx_k%0d", k), bus.IDX, ((k - 32) / 2) % 2);
      check($sformatf("t3n_upd_k%0d", k), bus.IDX_UPDATE, (k % 2) == 0);
    end

    // Sync coinciding with the divider terminal that would move IDX 2->3
    bus.CYCLE_M    = 16'd3;
    bus.FREQ_DIV_M = 32'd4;
    bus.SYNC_SET   = 1'b1;
    tick();
    bus.SYNC_SET = 1'b0;
    check("t4_idx0", bus.IDX, 0);
    check("t4_upd0", bus.IDX_UPDATE, 1);
    for (int k = 1; k <= 11; k++) begin
      tick();
      check($sformatf("t4_idx_k%0d", k), bus.IDX, k / 4);
      check($sformatf("t4_upd_k%0d", k), bus.IDX_UPDATE, (k % 4) == 0);
    end
    bus.SYNC_SET = 1'b1;
    tick();
    check("t4_sync_idx", bus.IDX, 0);
    check("t4_sync_upd", bus.IDX_UPDATE, 1);
    for (int k = 13; k <= 20; k++) begin
      tick();
      check($sformatf("t4h_idx_k%0d", k), bus.IDX, (k - 12) / 4);
      check($sformatf("t4h_upd_k%0d", k), bus.IDX_UPDATE, ((k - 12) % 4) == 0);
    end

    // FREQ_DIV_M=0 behaves as divide-by-1
    bus.SYNC_SET = 1'b0;
    tick();
    bus.CYCLE_M    = 16'd2;
    bus.FREQ_DIV_M = 32'd0;
    bus.SYNC_SET   = 1'b1;
    tick();
    bus.SYNC_SET = 1'b0;
    check("t2_idx0", bus.IDX, 0);
    check("t2_upd0", bus.IDX_UPDATE, 1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("t2_idx_k%0d", k), bus.IDX, k % 3);
      check($sformatf("t2_upd_k%0d", k), bus.IDX_UPDATE, 1);
    end

    // One-cycle reset mid-run, then idle until the next sync
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_idx", bus.IDX, 0);
    check("t5_upd", bus.IDX_UPDATE, 0);
    check("t5_run", bus.RUNNING, 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("t5_idle_idx_k%0d", k), bus.IDX, 0);
      check($sformatf("t5_idle_upd_k%0d", k), bus.IDX_UPDATE, 0);
      check($sformatf("t5_idle_run_k%0d", k), bus.RUNNING, 0);
    end

`ifdef MOD_TIMER_LOOP_CNT_EN
    // Every cycle is a period boundary with cycle 0 / div 1
    bus.CYCLE_M    = 16'd0;
    bus.FREQ_DIV_M = 32'd1;
    bus.SYNC_SET   = 1'b1;
    tick();
    bus.SYNC_SET = 1'b0;
    check("lc_clr", bus.LOOP_CNT, 0);
    tick();
    check("lc_one", bus.LOOP_CNT, 1);
    check("lc_idx", bus.IDX, 0);
    check("lc_upd", bus.IDX_UPDATE, 1);
    repeat (65534) tick();
    check("lc_max", bus.LOOP_CNT, 16'hFFFF);
    tick();
    check("lc_sat", bus.LOOP_CNT, 16'hFFFF);
    bus.SYNC_SET = 1'b1;
    tick();
    bus.SYNC_SET = 1'b0;
    check("lc_resync", bus.LOOP_CNT, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
